// File: rtl/null_sink_stats_if.sv
// Stream interface for the null sink: 64-bit CHDR AXI-stream, data/last/valid
// flow toward the sink, ready flows back.
interface null_sink_stats_if;
    logic [63:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        i_tready;

    modport master (output i_tdata, output i_tlast, output i_tvalid, input  i_tready);
    modport slave  (input  i_tdata, input  i_tlast, input  i_tvalid, output i_tready);
endinterface

// File: rtl/null_sink_stats.sv
// null_sink_stats: terminating CHDR sink that accepts and discards every
// beat while gathering packet/line/cycle counts plus sequence and length
// error statistics, readable via a registered 4-entry readback port.
// Optional build macro NULL_SINK_PAYLOAD_CHECK_EN adds a per-beat payload
// index checker (pay_err) and moves last_seq to readback word 2.
module null_sink_stats #(
    parameter logic [7:0] SR_ENABLE      = 8'd132,
    parameter logic [7:0] SR_THROTTLE    = 8'd133,
    parameter logic [7:0] SR_CLEAR_STATS = 8'd134
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     set_stb,
    input  logic [7:0]               set_addr,
    input  logic [31:0]              set_data,
    null_sink_stats_if.slave         s_axis,
    input  logic [1:0]               rb_addr,
    output logic [63:0]              rb_data
);

    typedef enum logic {ST_HDR, ST_BODY} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_enable;
    logic [15:0] r_gap_n, r_gap;
    logic        r_tready;
    logic [15:0] r_beat_idx, r_exp_lines;
    logic        r_has_time;
    logic        r_armed;
    logic [11:0] r_exp_seq;
    logic [15:0] r_seq_err, r_len_err;
    logic [31:0] r_pkt_count;
    logic [47:0] r_line_count, r_cycle_count;
    logic        r_cyc_run;
    logic [31:0] r_last_sid;
    logic [11:0] r_last_seq;
    logic [15:0] r_last_len;
    logic [31:0] r_cur_sid;
    logic [11:0] r_cur_seq;
    logic [15:0] r_cur_len;

    logic        w_wr_en, w_wr_n, w_clr, w_beat, w_cnt, w_is_hdr, w_eop;
    logic [11:0] w_hdr_seq;
    logic [15:0] w_hdr_len, w_hdr_lines, w_beats_now, w_exp_now, w_gap_nxt;
    logic [16:0] w_len_round;
    logic        w_unused;

    assign w_wr_en   = set_stb && (set_addr == SR_ENABLE);
    assign w_wr_n    = set_stb && (set_addr == SR_THROTTLE);
    // Clear wins over any beat in the same cycle.
    assign w_clr     = clear | (set_stb && (set_addr == SR_CLEAR_STATS));
    assign w_beat    = s_axis.i_tvalid & r_tready;
    assign w_cnt     = w_beat & r_enable & ~w_clr;
    assign w_is_hdr  = (r_state == ST_HDR);
    assign w_eop     = w_cnt & s_axis.i_tlast;

    assign w_hdr_seq   = s_axis.i_tdata[59:48];
    assign w_hdr_len   = s_axis.i_tdata[47:32];
    assign w_len_round = {1'b0, w_hdr_len} + 17'd7;
    assign w_hdr_lines = {3'd0, w_len_round[16:3]};
    // Beats seen so far in this packet including the current one.
    assign w_beats_now = w_is_hdr ? 16'd1 : ((&r_beat_idx) ? r_beat_idx : r_beat_idx + 16'd1);
    assign w_exp_now   = w_is_hdr ? w_hdr_lines : r_exp_lines;
    assign w_gap_nxt   = (r_gap >= r_gap_n) ? 16'd0 : r_gap + 16'd1;

    assign s_axis.i_tready = r_tready;
    assign w_unused = &{1'b0, set_data[31:16], s_axis.i_tdata[63:60]};

    // Settings registers: enable and throttle gap survive clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_enable <= 1'b0;
            r_gap_n  <= 16'd0;
        end else begin
            if (w_wr_en) r_enable <= set_data[0];
            if (w_wr_n)  r_gap_n  <= set_data[15:0];
        end
    end

    // Ready throttle: high one cycle then low N cycles; a write to N or a clear restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tready <= 1'b1;
            r_gap    <= 16'd0;
        end else if (w_wr_n || w_clr || r_gap_n == 16'd0) begin
            r_tready <= 1'b1;
            r_gap    <= 16'd0;
        end else begin
            r_gap    <= w_gap_nxt;
            r_tready <= (w_gap_nxt == 16'd0);
        end
    end

    // Parser state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_HDR;
        else          r_state <= w_state_nxt;
    end

    // Parser next state: tracks packet framing regardless of enable.
    always_comb begin
        w_state_nxt = r_state;
        if (w_clr) begin
            w_state_nxt = ST_HDR;
        end else if (w_beat) begin
            case (r_state)
                ST_HDR:  if (!s_axis.i_tlast) w_state_nxt = ST_BODY;
                ST_BODY: if (s_axis.i_tlast)  w_state_nxt = ST_HDR;
                default: w_state_nxt = ST_HDR;
            endcase
        end
    end

    // Per-packet tracking: beat index, expected lines, current header fields.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_beat_idx  <= 16'd0;
            r_exp_lines <= 16'd0;
            r_has_time  <= 1'b0;
            r_cur_sid   <= 32'd0;
            r_cur_seq   <= 12'd0;
            r_cur_len   <= 16'd0;
        end else if (w_clr) begin
            r_beat_idx  <= 16'd0;
            r_exp_lines <= 16'd0;
            r_has_time  <= 1'b0;
            r_cur_sid   <= 32'd0;
            r_cur_seq   <= 12'd0;
            r_cur_len   <= 16'd0;
        end else if (w_beat) begin
            r_beat_idx <= w_beats_now;
            if (w_is_hdr) begin
                r_exp_lines <= w_hdr_lines;
                r_has_time  <= s_axis.i_tdata[61];
                r_cur_sid   <= s_axis.i_tdata[31:0];
                r_cur_seq   <= w_hdr_seq;
                r_cur_len   <= w_hdr_len;
            end
        end
    end

    // Sequence check: first header after reset/clear/enable-rise only arms.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_armed   <= 1'b0;
            r_exp_seq <= 12'd0;
            r_seq_err <= 16'd0;
        end else if (w_clr) begin
            r_armed   <= 1'b0;
            r_exp_seq <= 12'd0;
            r_seq_err <= 16'd0;
        end else begin
            if (w_cnt && w_is_hdr) begin
                r_armed   <= 1'b1;
                r_exp_seq <= w_hdr_seq + 12'd1;
                if (r_armed && w_hdr_seq != r_exp_seq && !(&r_seq_err))
                    r_seq_err <= r_seq_err + 16'd1;
            end
            if (w_wr_en && set_data[0] && !r_enable)
                r_armed <= 1'b0;
        end
    end

    // Packet/line/length statistics and last-header latch at end of packet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pkt_count  <= 32'd0;
            r_len_err    <= 16'd0;
            r_line_count <= 48'd0;
            r_last_sid   <= 32'd0;
            r_last_seq   <= 12'd0;
            r_last_len   <= 16'd0;
        end else if (w_clr) begin
            r_pkt_count  <= 32'd0;
            r_len_err    <= 16'd0;
            r_line_count <= 48'd0;
            r_last_sid   <= 32'd0;
            r_last_seq   <= 12'd0;
            r_last_len   <= 16'd0;
        end else begin
            if (w_cnt && !(&r_line_count)) r_line_count <= r_line_count + 48'd1;
            if (w_eop) begin
                if (!(&r_pkt_count)) r_pkt_count <= r_pkt_count + 32'd1;
                if (w_beats_now != w_exp_now && !(&r_len_err))
                    r_len_err <= r_len_err + 16'd1;
                r_last_sid <= w_is_hdr ? s_axis.i_tdata[31:0] : r_cur_sid;
                r_last_seq <= w_is_hdr ? w_hdr_seq : r_cur_seq;
                r_last_len <= w_is_hdr ? w_hdr_len : r_cur_len;
            end
        end
    end

    // Active-cycle counter: runs from the first counted beat until enable drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cyc_run     <= 1'b0;
            r_cycle_count <= 48'd0;
        end else if (w_clr) begin
            r_cyc_run     <= 1'b0;
            r_cycle_count <= 48'd0;
        end else if (!r_enable) begin
            r_cyc_run <= 1'b0;
        end else begin
            if (w_cnt) r_cyc_run <= 1'b1;
            if ((w_cnt || r_cyc_run) && !(&r_cycle_count))
                r_cycle_count <= r_cycle_count + 48'd1;
        end
    end

`ifdef NULL_SINK_PAYLOAD_CHECK_EN
    logic [15:0] r_pay_err;
    logic [15:0] w_pay_idx;
    logic        w_time_word;

    assign w_time_word = r_has_time && (r_beat_idx == 16'd1);
    assign w_pay_idx   = r_beat_idx - 16'd1 - {15'd0, r_has_time};

    // Payload checker: body payload beats must carry their index in [15:0].
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_pay_err <= 16'd0;
        else if (w_clr)
            r_pay_err <= 16'd0;
        else if (w_cnt && !w_is_hdr && !w_time_word &&
                 s_axis.i_tdata[15:0] != w_pay_idx && !(&r_pay_err))
            r_pay_err <= r_pay_err + 16'd1;
    end
`endif

    // Registered readback mux.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rb_data <= 64'd0;
        end else if (w_clr) begin
            rb_data <= 64'd0;
        end else begin
            case (rb_addr)
                2'd0: rb_data <= {r_seq_err, r_len_err, r_pkt_count};
                2'd1: rb_data <= {16'd0, r_line_count};
`ifdef NULL_SINK_PAYLOAD_CHECK_EN
                2'd2: rb_data <= {4'd0, r_last_seq, r_cycle_count};
                default: rb_data <= {r_last_sid, r_pay_err, r_last_len};
`else
                2'd2: rb_data <= {16'd0, r_cycle_count};
                default: rb_data <= {r_last_sid, 4'd0, r_last_seq, r_last_len};
`endif
            endcase
        end
    end

endmodule

// File: tb/tb_null_sink_stats.sv
// Directed self-checking bench for null_sink_stats.
module tb_null_sink_stats;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = 8'd0;
    logic [31:0] set_data = 32'd0;
    logic [1:0]  rb_addr = 2'd0;
    logic [63:0] rb_data;
    int          tests = 0;
    int          fails = 0;
    int          stalls = 0;

    null_sink_stats_if ifc ();

    null_sink_stats dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .set_stb  (set_stb),
        .set_addr (set_addr),
        .set_data (set_data),
        .s_axis   (ifc.slave),
        .rb_addr  (rb_addr),
        .rb_data  (rb_data)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] hdr(input logic [11:0] seq, input logic [15:0] len,
                                        input logic [31:0] sid);
        return {4'b0000, seq, len, sid};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic setw(input logic [7:0] a, input logic [31:0] d);
        set_stb = 1'b1; set_addr = a; set_data = d;
        tick();
        set_stb = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [63:0] v);
        rb_addr = a;
        tick();
        v = rb_data;
    endtask

    // Sends one packet; body payload k carries k, except index 'bad' carries 7.
    task automatic send_pkt(input logic [11:0] seq, input logic [15:0] len, input int nbeats,
                            input logic [31:0] sid, input int bad);
        for (int b = 0; b < nbeats; b++) begin
            logic r;
            int   guard;
            ifc.i_tvalid = 1'b1;
            ifc.i_tlast  = (b == nbeats - 1);
            if (b == 0) ifc.i_tdata = hdr(seq, len, sid);
            else        ifc.i_tdata = {48'd0, (b - 1 == bad) ? 16'd7 : 16'(b - 1)};
            guard = 0;
            do begin
                r = ifc.i_tready;
                if (!r) stalls++;
                tick();
                guard++;
            end while (!r && guard < 64);
            if (!r) chk("ready_timeout", 64'(r), 64'd1);
        end
        ifc.i_tvalid = 1'b0;
        ifc.i_tlast  = 1'b0;
    endtask

    initial begin
        logic [63:0] v;
        int          pat_err, acc, bi;
        ifc.i_tvalid = 1'b0; ifc.i_tlast = 1'b0; ifc.i_tdata = 64'd0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Reset state
        chk("rst_tready", 64'(ifc.i_tready), 64'd1);
        rd(2'd0, v); chk("rst_rb0", v, 64'd0);
        rd(2'd1, v); chk("rst_rb1", v, 64'd0);
        rd(2'd2, v); chk("rst_rb2", v, 64'd0);
        rd(2'd3, v); chk("rst_rb3", v, 64'd0);

        // Four clean 5-line packets, seq 0..3, no throttling
        setw(8'd132, 32'd1);
        stalls = 0;
        for (int s = 0; s < 4; s++) send_pkt(12'(s), 16'd40, 5, 32'hA0, -1);
        chk("n0_no_stall", 64'(stalls), 64'd0);
        rd(2'd0, v); chk("clean_rb0", v, {16'd0, 16'd0, 32'd4});
        rd(2'd1, v); chk("clean_lines", v, 64'd20);
        rd(2'd3, v);
`ifdef NULL_SINK_PAYLOAD_CHECK_EN
        chk("clean_rb3", v, {32'hA0, 16'd0, 16'd40});
`else
        chk("clean_rb3", v, {32'hA0, 4'd0, 12'd3, 16'd40});
`endif

        // Sequence gap then resync
        setw(8'd134, 32'd0);
        send_pkt(12'd10, 16'd40, 5, 32'h1, -1);
        send_pkt(12'd11, 16'd40, 5, 32'h1, -1);
        send_pkt(12'd13, 16'd40, 5, 32'h1, -1);
        send_pkt(12'd14, 16'd40, 5, 32'h1, -1);
        rd(2'd0, v); chk("seq_gap", v, {16'd1, 16'd0, 32'd4});

        // Legal 4095 -> 0 wrap
        setw(8'd134, 32'd0);
        send_pkt(12'd4094, 16'd40, 5, 32'h2, -1);
        send_pkt(12'd4095, 16'd40, 5, 32'h2, -1);
        send_pkt(12'd0,    16'd40, 5, 32'h2, -1);
        rd(2'd0, v); chk("seq_wrap", v, {16'd0, 16'd0, 32'd3});

        // Short packet (6 lines claimed, 5 sent) then single-beat len 8
        setw(8'd134, 32'd0);
        send_pkt(12'd0, 16'd48, 5, 32'h3, -1);
        send_pkt(12'd1, 16'd8,  1, 32'h4, -1);
        rd(2'd0, v); chk("len_err", v, {16'd0, 16'd1, 32'd2});
        rd(2'd1, v); chk("len_lines", v, 64'd6);

        // Throttle N=3: continuous valid over 32 cycles, disable on last beat
        setw(8'd134, 32'd0);
        setw(8'd133, 32'd3);
        pat_err = 0; acc = 0; bi = 0;
        for (int i = 0; i < 32; i++) begin
            logic r;
            r = ifc.i_tready;
            if (r !== ((i % 4) == 0)) pat_err++;
            if (bi < 8) begin
                ifc.i_tvalid = 1'b1;
                ifc.i_tlast  = ((bi % 4) == 3);
                ifc.i_tdata  = ((bi % 4) == 0) ? hdr(12'(bi / 4), 16'd32, 32'h5)
                                               : {48'd0, 16'((bi % 4) - 1)};
            end else begin
                ifc.i_tvalid = 1'b0;
                ifc.i_tlast  = 1'b0;
            end
            if (r && bi == 7) begin
                set_stb = 1'b1; set_addr = 8'd132; set_data = 32'd0;
            end
            tick();
            set_stb = 1'b0;
            if (r && bi < 8) begin acc++; bi++; end
        end
        ifc.i_tvalid = 1'b0; ifc.i_tlast = 1'b0;
        chk("thr_pattern", 64'(pat_err), 64'd0);
        chk("thr_accepts", 64'(acc), 64'd8);
        rd(2'd0, v); chk("thr_rb0", v, {16'd0, 16'd0, 32'd2});
        rd(2'd1, v); chk("thr_lines", v, 64'd8);
        rd(2'd2, v);
`ifdef NULL_SINK_PAYLOAD_CHECK_EN
        chk("thr_cycles", v, {4'd0, 12'd1, 48'd29});
`else
        chk("thr_cycles", v, {16'd0, 48'd29});
`endif
        setw(8'd133, 32'd0);

        // Asynchronous reset mid-packet
        setw(8'd132, 32'd1);
        ifc.i_tvalid = 1'b1; ifc.i_tlast = 1'b0;
        ifc.i_tdata = hdr(12'd3, 16'd40, 32'h6);
        tick();
        ifc.i_tdata = 64'd0;
        tick();
        ifc.i_tvalid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_tready", 64'(ifc.i_tready), 64'd1);
        chk("arst_rbdata", rb_data, 64'd0);
        tick();
        #3 reset_n = 1'b1;
        tick();
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v); chk("arst_rb", v, 64'd0);
        end

        // Clear coincident with a beat drops that beat
        setw(8'd132, 32'd1);
        ifc.i_tvalid = 1'b1; ifc.i_tlast = 1'b1;
        ifc.i_tdata = hdr(12'd9, 16'd8, 32'h7);
        clear = 1'b1;
        tick();
        clear = 1'b0; ifc.i_tvalid = 1'b0; ifc.i_tlast = 1'b0;
        send_pkt(12'd7, 16'd40, 5, 32'h8, -1);
        rd(2'd0, v); chk("post_rst_rb0", v, {16'd0, 16'd0, 32'd1});
        rd(2'd1, v); chk("post_rst_lines", v, 64'd5);

`ifdef NULL_SINK_PAYLOAD_CHECK_EN
        // Payload 0,1,7,3 -> one payload error
        setw(8'd134, 32'd0);
        send_pkt(12'd5, 16'd40, 5, 32'h9, 2);
        rd(2'd3, v); chk("pay_err", v, {32'h9, 16'd1, 16'd40});
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
